fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO, parametrised in address width. It replaces the fixed 4-bit, one-slot-wasted full compare with an (ADDR_W+1)-bit wrap-bit pointer scheme, so all DEPTH entries are usable. It adds an internal read-pointer synchroniser, a registered full flag, a fill level, almost_full and a sticky overflow error. It sits between the write-side user interface and the dual-port RAM / read-side controller.

Parameters:
ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W; ADDR_W >= 1
SYNC_STAGES, 2, flops in the read-pointer synchroniser; >= 2
AF_MARGIN, 2, almost_full asserts when level >= DEPTH - AF_MARGIN; 1 <= AF_MARGIN < DEPTH

Ports:
write_clk  in  1  write-domain clock; the only clock
rst  in  1  synchronous, active-high reset, sampled on write_clk rising edge
wr_en  in  1  write request from user
ovf_clr  in  1  clears sticky overflow
rptr_gray_in  in  ADDR_W+1  Gray read pointer from read domain (asynchronous)
wr_fire  out  1  write accepted this cycle = wr_en & ~full (combinational); RAM write enable
wr_addr  out  ADDR_W  RAM write address = wptr_bin[ADDR_W-1:0]
wptr_gray  out  ADDR_W+1  registered Gray write pointer to read domain
full  out  1  registered full flag
almost_full  out  1  registered
wr_level  out  ADDR_W+1  registered fill level as seen from write domain, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (rst=1 at edge): wptr_bin, wptr_gray, all synchroniser flops, full, almost_full, wr_level and overflow all go to 0. rst overrides wr_en and ovf_clr. Mid-operation reset discards FIFO state. The read side is reset by its own controller.
- Sync: rptr_gray_in passes through SYNC_STAGES flops giving rsync. rbin = gray-to-binary of rsync.
- Pointer: wptr_bin_next = wptr_bin + wr_fire, modulo 2**(ADDR_W+1). Natural wrap; no saturation.
- Gray: wptr_gray <= wptr_bin_next ^ (wptr_bin_next >> 1). The registered output changes at most 1 bit per cycle.
- Full: full <= (gray(wptr_bin_next) == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]}). For ADDR_W=1, both bits are inverted.
  - full asserts on the same edge that registers the DEPTH-th outstanding write. There is no one-cycle-late window.
  - Deassertion lags read-domain pointer updates by SYNC_STAGES+1 write_clk edges. This is pessimistic and intended.
- Level: wr_level <= wptr_bin_next - rbin, using (ADDR_W+1)-bit modulo arithmetic. It is never above DEPTH.
- almost_full <= (level_next >= DEPTH - AF_MARGIN). It is always asserted whenever full is asserted.
- Overflow: set when wr_en & full. Cleared on the edge after ovf_clr=1. Simultaneous set and clear: set wins. The rejected write does not move the pointer.
- wr_en while full: wr_fire=0, wr_addr held, no RAM write.
- Outputs other than wr_fire/wr_addr are registered only. This avoids combinational paths from rptr_gray_in.

Decomposition:
- Shared package fifo_pkg holds:
  - ADDR_W default and DEPTH derivation
  - bin2gray function
  - the full-compare function (MSB-inversion rule), reused by the read-side empty logic
- One sub-module, gray2bin, parametrised WIDTH (ADDR_W+1), purely combinational prefix-XOR. It supersedes the fixed 4-bit decoder.
- The synchroniser stays inline as a flop array. It can be split into sync_nff later if CDC tooling requires it.

Test Plan (ADDR_W=3, DEPTH=8, SYNC_STAGES=2, AF_MARGIN=2):
1. rst=1 for 2 edges with wr_en=1, rptr_gray_in=4'b0110 -> all outputs 0, wptr_gray=0000, wr_addr=0, no wr_fire.
2. rptr_gray_in=0, wr_en=1 for 9 cycles:
   - wr_level steps 1..8, almost_full rises when wr_level=6, full rises when wr_level=8 (wptr_gray=1100).
   - 9th cycle: wr_fire=0, wr_addr stays 0, overflow=1.
3. From full, set rptr_gray_in=0010 (bin 3) -> full and almost_full drop exactly 3 edges later, wr_level=5.
4. Wrap: interleave writes with rptr_gray_in tracking 2 behind, for 20 writes -> wptr_gray goes 1000->0000 at bin 15->0 with a single bit change, full never asserts, wr_level stays 2.
5. Overflow set: drive overflow set (wr_en while full) and ovf_clr in the same cycle -> overflow stays 1.
6. Overflow clear and mid-operation reset:
   - Next cycle ovf_clr alone -> overflow=0.
   - Then pulse rst while full -> all outputs 0 next edge, and first write after reset uses wr_addr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO parameters and pointer helper functions
package fifo_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray pointers are one full lap apart when the top two bits differ and the rest match.
    // Zero-extended 32-bit operands let one function serve any pointer width.
    function automatic logic full_match(input logic [31:0] wg, input logic [31:0] rg,
                                        input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return ((wg ^ rg ^ (32'd3 << (aw - 1))) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// rtl/fifo_wr_ctrl_if.sv - write-side user and pointer-exchange signal bundle
interface fifo_wr_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic              ovf_clr;
    logic [ADDR_W:0]   rptr_gray_in;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wptr_gray;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              overflow;

    modport master (
        output wr_en, ovf_clr, rptr_gray_in,
        input  wr_fire, wr_addr, wptr_gray, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  wr_en, ovf_clr, rptr_gray_in,
        output wr_fire, wr_addr, wptr_gray, full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// rtl/fifo_wr_ctrl_gray2bin.sv - combinational Gray-to-binary prefix-XOR decoder
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write pointer, full/level flags and overflow tracking
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2
) (
    input  logic           write_clk,
    input  logic           rst,
    fifo_wr_ctrl_if.slave  bus
);
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_bin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] level_next;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;
    logic          full_next;

    assign rsync = sync_q[SYNC_STAGES-1];

    gray2bin #(.WIDTH(PW)) u_rptr_dec (
        .gray (rsync),
        .bin  (rbin)
    );

    // Writes are suppressed during reset so the RAM never sees a stray enable.
    assign bus.wr_fire    = bus.wr_en & ~bus.full & ~rst;
    assign bus.wr_addr    = wptr_bin[ADDR_W-1:0];
    assign wptr_bin_next  = wptr_bin + PW'(bus.wr_fire);
    assign wgray_next     = PW'(bin2gray(32'(wptr_bin_next)));
    assign level_next     = wptr_bin_next - rbin;
    assign full_next      = full_match(32'(wgray_next), 32'(rsync), ADDR_W);

    always_ff @(posedge write_clk) begin
        if (rst) begin
            wptr_bin        <= '0;
            bus.wptr_gray   <= '0;
            bus.full        <= 1'b0;
            bus.almost_full <= 1'b0;
            bus.wr_level    <= '0;
            bus.overflow    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            wptr_bin        <= wptr_bin_next;
            bus.wptr_gray   <= wgray_next;
            bus.full        <= full_next;
            bus.almost_full <= (level_next >= AF_LEVEL);
            bus.wr_level    <= level_next;
            sync_q[0]       <= bus.rptr_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            // A rejected write in the same cycle as a clear keeps the error visible.
            if (bus.wr_en && bus.full)
                bus.overflow <= 1'b1;
            else if (bus.ovf_clr)
                bus.overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;
    localparam int AW = 3;

    logic write_clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   wp    = 0;

    fifo_wr_ctrl_if #(.ADDR_W(AW)) bus ();

    fifo_wr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(2), .AF_MARGIN(2)) dut (
        .write_clk (write_clk),
        .rst       (rst),
        .bus       (bus.slave)
    );

    always #5 write_clk = ~write_clk;

    function automatic logic [3:0] g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.wr_en = 1'b1; bus.ovf_clr = 1'b0; bus.rptr_gray_in = 4'b0110;
        tick(); tick();
        total++;
        if ({bus.wptr_gray, bus.full, bus.almost_full, bus.wr_level, bus.overflow} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs got gray=%b full=%b af=%b lvl=%0d ovf=%b want all 0",
                     bus.wptr_gray, bus.full, bus.almost_full, bus.wr_level, bus.overflow);
        end
        total++;
        if (bus.wr_fire !== 1'b0 || bus.wr_addr !== 3'd0) begin
            bad++;
            $display("FAIL reset_fire got fire=%b addr=%0d want 0/0", bus.wr_fire, bus.wr_addr);
        end
    endtask

    task automatic test_fill();
        int lvl;
        bus.wr_en = 1'b0; bus.rptr_gray_in = 4'b0000; rst = 1'b0;
        tick(); tick();
        wp = 0;
        for (int i = 1; i <= 9; i++) begin
            bus.wr_en = 1'b1;
            #1;
            total++;
            if (bus.wr_fire !== (i <= 8) || bus.wr_addr !== 3'((i <= 8) ? i - 1 : 0)) begin
                bad++;
                $display("FAIL fill_fire[%0d] got fire=%b addr=%0d want %b/%0d", i, bus.wr_fire,
                         bus.wr_addr, (i <= 8), (i <= 8) ? i - 1 : 0);
            end
            tick();
            lvl = (i <= 8) ? i : 8;
            total++;
            if (bus.wr_level !== 4'(lvl) || bus.almost_full !== (lvl >= 6) ||
                bus.full !== (lvl == 8) || bus.overflow !== (i == 9)) begin
                bad++;
                $display("FAIL fill_flags[%0d] got lvl=%0d af=%b full=%b ovf=%b want %0d/%b/%b/%b",
                         i, bus.wr_level, bus.almost_full, bus.full, bus.overflow,
                         lvl, (lvl >= 6), (lvl == 8), (i == 9));
            end
        end
        wp = 8;
        total++;
        if (bus.wptr_gray !== 4'b1100) begin
            bad++;
            $display("FAIL full_gray got %b want 1100", bus.wptr_gray);
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_release();
        bus.rptr_gray_in = 4'b0010;
        tick(); tick();
        total++;
        if (bus.full !== 1'b1 || bus.almost_full !== 1'b1) begin
            bad++;
            $display("FAIL release_early got full=%b af=%b want 1/1", bus.full, bus.almost_full);
        end
        tick();
        total++;
        if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.wr_level !== 4'd5) begin
            bad++;
            $display("FAIL release_edge3 got full=%b af=%b lvl=%0d want 0/0/5",
                     bus.full, bus.almost_full, bus.wr_level);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        bus.rptr_gray_in = g(wp - 2);
        tick(); tick(); tick();
        for (int i = 0; i < 20; i++) begin
            prev = bus.wptr_gray;
            bus.wr_en = 1'b1;
            tick();
            bus.wr_en = 1'b0;
            wp = (wp + 1) % 16;
            total++;
            if (bus.wptr_gray !== g(wp) || $countones(bus.wptr_gray ^ prev) != 1) begin
                bad++;
                $display("FAIL wrap_gray[%0d] got %b (prev %b) want %b", i, bus.wptr_gray, prev, g(wp));
            end
            if (wp == 0) begin
                total++;
                if (prev !== 4'b1000 || bus.wptr_gray !== 4'b0000) begin
                    bad++;
                    $display("FAIL wrap_15_to_0 got %b->%b want 1000->0000", prev, bus.wptr_gray);
                end
            end
            bus.rptr_gray_in = g(wp - 2);
            tick(); tick(); tick();
            total++;
            if (bus.wr_level !== 4'd2 || bus.full !== 1'b0) begin
                bad++;
                $display("FAIL wrap_level[%0d] got lvl=%0d full=%b want 2/0", i, bus.wr_level, bus.full);
            end
        end
    endtask

    task automatic test_ovf_set_wins();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear_pre got %b want 0", bus.overflow);
        end
        bus.wr_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        wp = (wp + 6) % 16;
        total++;
        if (bus.full !== 1'b1 || bus.wr_level !== 4'd8 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL refill got full=%b lvl=%0d ovf=%b want 1/8/0", bus.full, bus.wr_level, bus.overflow);
        end
        bus.ovf_clr = 1'b1;
        #1;
        total++;
        if (bus.wr_fire !== 1'b0) begin
            bad++;
            $display("FAIL ovf_fire got %b want 0", bus.wr_fire);
        end
        tick();
        bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
        total++;
        if (bus.overflow !== 1'b1 || bus.wptr_gray !== g(wp)) begin
            bad++;
            $display("FAIL ovf_set_wins got ovf=%b gray=%b want 1/%b", bus.overflow, bus.wptr_gray, g(wp));
        end
    endtask

    task automatic test_clear_and_reset();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        total++;
        if (bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
            bad++;
            $display("FAIL ovf_clear got ovf=%b full=%b want 0/1", bus.overflow, bus.full);
        end
        rst = 1'b1; bus.rptr_gray_in = 4'b0000;
        tick();
        rst = 1'b0;
        total++;
        if ({bus.wptr_gray, bus.full, bus.almost_full, bus.wr_level, bus.overflow} !== 11'd0 ||
            bus.wr_addr !== 3'd0) begin
            bad++;
            $display("FAIL midreset got gray=%b full=%b af=%b lvl=%0d ovf=%b addr=%0d want all 0",
                     bus.wptr_gray, bus.full, bus.almost_full, bus.wr_level, bus.overflow, bus.wr_addr);
        end
        bus.wr_en = 1'b1;
        #1;
        total++;
        if (bus.wr_fire !== 1'b1 || bus.wr_addr !== 3'd0) begin
            bad++;
            $display("FAIL first_write got fire=%b addr=%0d want 1/0", bus.wr_fire, bus.wr_addr);
        end
        tick();
        bus.wr_en = 1'b0;
        total++;
        if (bus.wr_level !== 4'd1 || bus.wptr_gray !== 4'b0001) begin
            bad++;
            $display("FAIL after_first got lvl=%0d gray=%b want 1/0001", bus.wr_level, bus.wptr_gray);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_wrap();
        test_ovf_set_wins();
        test_clear_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
